// File: rtl/gray_counter.sv
// Registered up/down Gray-code counter with parallel load, wrap/saturate mode
// and a one-cycle terminal-count pulse. Binary and Gray views update together.
module gray_counter #(
   parameter int unsigned          SIZE      = 8,
   parameter bit                   WRAP      = 1'b1,
   parameter logic [SIZE-1:0]      RESET_VAL = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            up_dn,
   input  logic            load,
   input  logic [SIZE-1:0] load_bin,
   output logic [SIZE-1:0] bin,
   output logic [SIZE-1:0] gray,
   output logic            tc
);

   localparam logic [SIZE-1:0] MAX_VAL   = '1;
   localparam logic [SIZE-1:0] MIN_VAL   = '0;
   localparam logic [SIZE-1:0] ONE       = SIZE'(1);
   localparam logic [SIZE-1:0] RESET_GRY = RESET_VAL ^ (RESET_VAL >> 1);

   logic [SIZE-1:0] next_bin;
   logic [SIZE-1:0] next_gray;
   logic            next_tc;

   always_comb begin
      // NOTE: defaults first so every path assigns every output -- no latches.
      next_bin = bin;
      next_tc  = 1'b0;
      if (load) begin
         next_bin = load_bin;
      end else if (en) begin
         if (up_dn) begin
            if (bin == MAX_VAL) begin
               next_tc  = 1'b1;
               next_bin = WRAP ? MIN_VAL : bin;
            end else begin
               next_bin = bin + ONE;
            end
         end else begin
            if (bin == MIN_VAL) begin
               next_tc  = 1'b1;
               next_bin = WRAP ? MAX_VAL : bin;
            end else begin
               next_bin = bin - ONE;
            end
         end
      end
   end

   // Gray is encoded before the register so the output is a clean flop.
   assign next_gray = next_bin ^ (next_bin >> 1);

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking assignments keep all three registers updating on the same edge.
      if (rst) begin
         bin  <= RESET_VAL;
         gray <= RESET_GRY;
         tc   <= 1'b0;
      end else begin
         bin  <= next_bin;
         gray <= next_gray;
         tc   <= next_tc;
      end
   end

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter: three 4-bit instances (wrap, saturate,
// RESET_VAL=5) share stimulus; a reference model predicts each output.
`timescale 1ns/1ps
module tb_gray_counter;

   typedef struct packed {
      logic [1:0] idx;
      logic [3:0] bin;
      logic [3:0] gray;
      logic       tc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       up_dn;
   logic       load;
   logic [3:0] load_bin;

   logic [3:0] bin_v  [3];
   logic [3:0] gray_v [3];
   logic       tc_v   [3];

   bit         wrap_cfg [3] = '{1'b1, 1'b0, 1'b1};
   logic [3:0] rst_cfg  [3] = '{4'h0, 4'h0, 4'h5};
   logic [3:0] m_bin    [3];

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   gray_counter #(.SIZE(4), .WRAP(1'b1), .RESET_VAL(4'h0)) dut_wrap (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_bin(load_bin),
      .bin(bin_v[0]), .gray(gray_v[0]), .tc(tc_v[0]));

   gray_counter #(.SIZE(4), .WRAP(1'b0), .RESET_VAL(4'h0)) dut_sat (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_bin(load_bin),
      .bin(bin_v[1]), .gray(gray_v[1]), .tc(tc_v[1]));

   gray_counter #(.SIZE(4), .WRAP(1'b1), .RESET_VAL(4'h5)) dut_rv5 (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_bin(load_bin),
      .bin(bin_v[2]), .gray(gray_v[2]), .tc(tc_v[2]));

   function automatic exp_t model_step(input logic [1:0] idx, input logic [3:0] b,
                                       input bit wrap, input logic e, input logic u,
                                       input logic l, input logic [3:0] lb);
      exp_t r;
      r.idx = idx;
      r.bin = b;
      r.tc  = 1'b0;
      if (l) begin
         r.bin = lb;
      end else if (e) begin
         if (u) begin
            if (b == 4'hF) begin r.tc = 1'b1; r.bin = wrap ? 4'h0 : b; end
            else r.bin = b + 4'd1;
         end else begin
            if (b == 4'h0) begin r.tc = 1'b1; r.bin = wrap ? 4'hF : b; end
            else r.bin = b - 4'd1;
         end
      end
      r.gray = r.bin ^ (r.bin >> 1);
      return r;
   endfunction

   // One clock of stimulus: predict, push, clock, then pop and compare all instances.
   task automatic step(input logic e, input logic u, input logic l, input logic [3:0] lb);
      exp_t x;
      @(negedge clk);
      en = e; up_dn = u; load = l; load_bin = lb;
      for (int i = 0; i < 3; i++) begin
         x = model_step(2'(i), m_bin[i], wrap_cfg[i], e, u, l, lb);
         m_bin[i] = x.bin;
         sb.push_back(x);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty dut%0d", i);
         end else begin
            x = sb.pop_front();
            if (bin_v[x.idx] !== x.bin || gray_v[x.idx] !== x.gray || tc_v[x.idx] !== x.tc) begin
               fails++;
               $display("FAIL sb dut%0d got bin=%h gray=%h tc=%b want bin=%h gray=%h tc=%b",
                        x.idx, bin_v[x.idx], gray_v[x.idx], tc_v[x.idx], x.bin, x.gray, x.tc);
            end
         end
      end
   endtask

   task automatic expect_reset_state(input string name);
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (bin_v[i] !== rst_cfg[i] || gray_v[i] !== (rst_cfg[i] ^ (rst_cfg[i] >> 1)) || tc_v[i] !== 1'b0) begin
            fails++;
            $display("FAIL %s dut%0d got bin=%h gray=%h tc=%b want bin=%h gray=%h tc=0",
                     name, i, bin_v[i], gray_v[i], tc_v[i], rst_cfg[i], rst_cfg[i] ^ (rst_cfg[i] >> 1));
         end
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      expect_reset_state("reset_async");
      @(posedge clk);
      #1;
      expect_reset_state("reset_hold");
      @(negedge clk);
      rst = 1'b0;
      en = 1'b0; up_dn = 1'b1; load = 1'b0; load_bin = 4'h0;
      for (int i = 0; i < 3; i++) m_bin[i] = rst_cfg[i];
      sb.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_bin = 4'h0;
      #1;
      expect_reset_state("reset_initial");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) m_bin[i] = rst_cfg[i];
      for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 4'h0);
      apply_reset();
   endtask

   task automatic test_count_up();
      logic [3:0] seq [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                               4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
      logic [3:0] prev;
      for (int k = 1; k <= 16; k++) begin
         prev = gray_v[0];
         step(1'b1, 1'b1, 1'b0, 4'h0);
         tests++;
         if (gray_v[0] !== seq[k % 16] || tc_v[0] !== (k == 16)) begin
            fails++;
            $display("FAIL count_up step %0d got gray=%h tc=%b want gray=%h tc=%b",
                     k, gray_v[0], tc_v[0], seq[k % 16], (k == 16));
         end
         tests++;
         if ($countones(prev ^ gray_v[0]) != 1) begin
            fails++;
            $display("FAIL one_bit step %0d got %h->%h want exactly one bit changed", k, prev, gray_v[0]);
         end
      end
   endtask

   task automatic test_count_down();
      apply_reset();
      step(1'b1, 1'b0, 1'b0, 4'h0);
      tests++;
      if (bin_v[0] !== 4'hF || gray_v[0] !== 4'h8 || tc_v[0] !== 1'b1) begin
         fails++;
         $display("FAIL down_wrap got bin=%h gray=%h tc=%b want bin=F gray=8 tc=1", bin_v[0], gray_v[0], tc_v[0]);
      end
      step(1'b1, 1'b0, 1'b0, 4'h0);
      tests++;
      if (bin_v[0] !== 4'hE || gray_v[0] !== 4'h9 || tc_v[0] !== 1'b0) begin
         fails++;
         $display("FAIL down_next got bin=%h gray=%h tc=%b want bin=E gray=9 tc=0", bin_v[0], gray_v[0], tc_v[0]);
      end
   endtask

   task automatic test_load_priority();
      step(1'b1, 1'b1, 1'b1, 4'hA);
      tests++;
      if (bin_v[0] !== 4'hA || gray_v[0] !== 4'hF || tc_v[0] !== 1'b0) begin
         fails++;
         $display("FAIL load_over_en got bin=%h gray=%h tc=%b want bin=A gray=F tc=0", bin_v[0], gray_v[0], tc_v[0]);
      end
   endtask

   task automatic test_saturate();
      step(1'b0, 1'b1, 1'b1, 4'hF);
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b1, 1'b0, 4'h0);
         tests++;
         if (bin_v[1] !== 4'hF || gray_v[1] !== 4'h8 || tc_v[1] !== 1'b1) begin
            fails++;
            $display("FAIL sat_hi %0d got bin=%h gray=%h tc=%b want bin=F gray=8 tc=1", k, bin_v[1], gray_v[1], tc_v[1]);
         end
      end
      step(1'b1, 1'b0, 1'b0, 4'h0);
      tests++;
      if (bin_v[1] !== 4'hE || tc_v[1] !== 1'b0) begin
         fails++;
         $display("FAIL sat_leave got bin=%h tc=%b want bin=E tc=0", bin_v[1], tc_v[1]);
      end
   endtask

   task automatic test_hold();
      step(1'b0, 1'b1, 1'b1, 4'h6);
      for (int k = 0; k < 5; k++) begin
         step(1'b0, k[0], 1'b0, 4'h3);
         tests++;
         if (bin_v[0] !== 4'h6 || gray_v[0] !== 4'h5 || tc_v[0] !== 1'b0) begin
            fails++;
            $display("FAIL hold %0d got bin=%h gray=%h tc=%b want bin=6 gray=5 tc=0", k, bin_v[0], gray_v[0], tc_v[0]);
         end
      end
   endtask

   task automatic test_random();
      logic e, u, l;
      for (int k = 0; k < 300; k++) begin
         e = ($urandom_range(0, 3) != 0);
         u = 1'($urandom_range(0, 1));
         l = ($urandom_range(0, 9) == 0);
         step(e, u, l, 4'($urandom_range(0, 15)));
         for (int i = 0; i < 3; i++) begin
            tests++;
            if (gray_v[i] !== (bin_v[i] ^ (bin_v[i] >> 1))) begin
               fails++;
               $display("FAIL rand_gray dut%0d cycle %0d got gray=%h want %h",
                        i, k, gray_v[i], bin_v[i] ^ (bin_v[i] >> 1));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_count_down();
      test_load_priority();
      test_saturate();
      test_hold();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
